fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the RV32 core's IF stage. It owns the program counter, drives the byte address into the combinational instruction memory, and registers each fetched word with its PC into a one-entry output slot. It hands that slot to decode over a valid/ready handshake, accepts branch/jump redirects from later stages, and stops fetching on misaligned or out-of-range addresses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `MEM_BYTES`, default 24: instruction memory size in bytes; valid fetch requires `pc + 4 <= MEM_BYTES`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `imem_addr`  out  32: byte address to instruction memory; always equals the internal PC (combinational from the PC register).
- `imem_rdata`  in  32: instruction word returned combinationally for `imem_addr`, little-endian.
- `if_valid`  out  1: output slot holds a valid instruction.
- `if_instr`  out  32: registered instruction.
- `if_pc`  out  32: registered PC of `if_instr`.
- `id_ready`  in  1: decode accepts the slot this cycle.
- `redirect_valid`  in  1: flush and redirect fetch.
- `redirect_pc`  in  32: redirect target.
- `halted`  out  1: state is HALT.
- `fault`  out  1: state is FAULT.

## Operation
- States:
  - RUN: normal fetch.
  - HALT: fetch stopped; slot drained.
  - FAULT: fetch stopped due to a bad address.
- Slot free condition: `!if_valid || id_ready`.
- A fetch is legal when `pc[1:0] == 0` and `pc + 4 <= MEM_BYTES`. The comparison is done in 33 bits so `pc` near 2^32 never wraps into range.
- RUN, no redirect, slot free, legal fetch: load `if_instr <= imem_rdata`, `if_pc <= pc`, `if_valid <= 1`, `pc <= pc + 4`.
- RUN, slot free, illegal fetch: `if_valid <= 0` and go to FAULT. PC is held so `imem_addr` shows the faulting address.
- RUN, slot not free: hold slot and PC (stall).
- Redirect (`redirect_valid=1`) has priority over everything else, in any state except FAULT:
  - `if_valid <= 0` (flush, including a slot being accepted the same cycle).
  - `pc <= redirect_pc`.
  - Next state is RUN.
  - A misaligned or out-of-range `redirect_pc` is not checked at redirect time. It faults on the next fetch attempt.
- FAULT: exited only by `rst`. Redirects are ignored.
- HALT: entered only via the zero-halt feature (see Configuration). Exited by a redirect.

## Timing
- Reset values:
  - `pc = RESET_PC`
  - `if_valid = 0`
  - `if_instr = 0`
  - `if_pc = 0`
  - state RUN, so `halted = 0` and `fault = 0`
- Fetch latency is 1 cycle: the word at `imem_addr` is on `if_instr` after the next rising edge. Throughput is one instruction per cycle while `id_ready = 1`.
- First valid instruction appears on the first rising edge after `rst` deasserts.
- Redirect penalty is 1 bubble: `if_valid = 0` for the cycle after the redirect edge, and the target instruction is valid the following cycle.
- Simultaneous accept and fetch in the same cycle is allowed; no bubble.
- Asserting `rst` mid-stream clears the slot immediately, without waiting for a clock edge.
- `if_instr` and `if_pc` must stay stable while `if_valid = 1` and `id_ready = 0`.
- `halted` and `fault` are registered and decoded from state.

## Configuration
- `FETCH_ZERO_HALT_EN` defined:
  - In RUN with the slot free and a legal fetch, if `imem_rdata == 32'h0000_0000`, the word is not loaded.
  - Set `if_valid <= 0`, hold the PC at the zero word, and go to HALT.
  - `halted` asserts the next cycle.
- `FETCH_ZERO_HALT_EN` undefined: an all-zero word is fetched like any other instruction, and HALT is unreachable (`halted` is tied 0).

## Test plan
- Reset then stream:
  - Setup: `RESET_PC = 0`, `MEM_BYTES = 24`, `id_ready = 1`, memory words W0..W4 at 0,4,8,12,16.
  - Required: `if_pc` = 0,4,8,12,16 on consecutive cycles after reset, `if_instr` = W0..W4.
- Stall:
  - Stimulus: drop `id_ready` for 3 cycles while `if_pc = 8`.
  - Required: `if_pc` and `if_instr` hold (8, W2) and `imem_addr` holds 12. On release, `if_pc = 12` the next cycle.
- Redirect:
  - Stimulus: `redirect_valid = 1`, `redirect_pc = 4` while `if_pc = 12` and `id_ready = 1`.
  - Required: next cycle `if_valid = 0`; following cycle `if_pc = 4`, `if_instr = W1`.
- Out of range and misaligned:
  - Stimulus: run to PC 24, or redirect to 32'h0000_0006.
  - Required: `fault = 1` the cycle after the fetch attempt, `if_valid = 0`, `imem_addr` = 24 (or 6), and later redirects are ignored.
- Zero halt (`FETCH_ZERO_HALT_EN` defined):
  - Stimulus: word at address 20 = 0.
  - Required: after W4 is accepted, `halted = 1` and `if_valid = 0`. A redirect to 0 resumes with `if_pc = 0` two cycles later.
  - Without the macro: `if_instr = 0` is delivered with `if_pc = 20`.
- Async reset:
  - Stimulus: assert `rst` between clock edges while `if_valid = 1`.
  - Required: `if_valid = 0` and `imem_addr = RESET_PC` before the next edge.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl bus bundle: instruction memory port, decode slot handshake,
// redirect input and status flags.
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        output halted,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: PC, one-entry output slot, redirect and fault.
// Optional FETCH_ZERO_HALT_EN: an all-zero fetched word halts fetch.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 24
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

`ifdef FETCH_ZERO_HALT_EN
    localparam bit ZERO_HALT = 1'b1;
`else
    localparam bit ZERO_HALT = 1'b0;
`endif

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic        slot_free;
    logic [32:0] fetch_end;
    logic        in_range;
    logic        aligned;
    logic        legal;
    logic        zero_word;
    logic        take_redirect;
    logic        fetch_try;
    logic        do_fault;
    logic        do_halt;
    logic        do_load;

    // 33-bit end address so a PC near the top of the space cannot wrap legal
    assign fetch_end = {1'b0, pc_q} + 33'd4;
    assign in_range  = fetch_end <= 33'(MEM_BYTES);
    assign aligned   = pc_q[1:0] == 2'b00;
    assign legal     = aligned && in_range;
    assign zero_word = ZERO_HALT && (bus.imem_rdata == 32'h0000_0000);

    assign slot_free     = !valid_q || bus.id_ready;
    assign take_redirect = bus.redirect_valid && (state_q != FAULT);
    assign fetch_try     = !take_redirect && (state_q == RUN) && slot_free;
    assign do_fault      = fetch_try && !legal;
    assign do_halt       = fetch_try && legal && zero_word;
    assign do_load       = fetch_try && legal && !zero_word;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        unique case (1'b1)
            take_redirect: begin
                valid_d = 1'b0;
                pc_d    = bus.redirect_pc;
                state_d = RUN;
            end
            do_fault: begin
                valid_d = 1'b0;
                state_d = FAULT;
            end
            do_halt: begin
                valid_d = 1'b0;
                state_d = HALT;
            end
            do_load: begin
                instr_d = bus.imem_rdata;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end
            default: ;
        endcase
        halted_d = ZERO_HALT && (state_d == HALT);
        fault_d  = state_d == FAULT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            ipc_q    <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ipc_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized run
// against a cycle-level reference model of the fetch rules.
module tb_fetch_ctrl;

`ifdef FETCH_ZERO_HALT_EN
    localparam bit ZH = 1'b1;
`else
    localparam bit ZH = 1'b0;
`endif
    localparam int MEMB = 24;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (MEMB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [6];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[1:0] == 2'b00 && a < 32'(MEMB)) return mem[a[4:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb bus.imem_rdata = mem_read(bus.imem_addr);

    // reference model: 0 = running, 1 = halted, 2 = faulted
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_v;
    int          m_mode;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_v = 1'b0; m_mode = 0;
    endtask

    task automatic model_step(input logic rdy, input logic rv,
                              input logic [31:0] rpc);
        longint unsigned endaddr;
        logic [31:0] w;
        if (m_mode != 2 && rv) begin
            m_v = 1'b0; m_pc = rpc; m_mode = 0;
        end else if (m_mode == 0 && (!m_v || rdy)) begin
            endaddr = longint'(m_pc) + 4;
            if ((m_pc % 4) != 0 || endaddr > MEMB) begin
                m_v = 1'b0; m_mode = 2;
            end else begin
                w = mem_read(m_pc);
                if (ZH && w == 32'h0) begin
                    m_v = 1'b0; m_mode = 1;
                end else begin
                    m_instr = w; m_ipc = m_pc; m_v = 1'b1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.if_valid); end
        if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.if_instr); end
        if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.if_pc); end
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
        if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", bus.fault); end
        rst = 1'b0;
        tick();
        checks += 3;
        if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", bus.if_valid); end
        if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h exp 0", bus.if_pc); end
        if (bus.if_instr !== mem[0]) begin errors++; $display("FAIL first_instr got %h exp %h", bus.if_instr, mem[0]); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks += 3;
            if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", i, bus.if_valid); end
            if (bus.if_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", i, bus.if_pc, 4 * i); end
            if (bus.if_instr !== mem[i]) begin errors++; $display("FAIL stream_instr%0d got %h exp %h", i, bus.if_instr, mem[i]); end
        end
    endtask

    task automatic test_stall();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (bus.if_pc !== 32'd8) begin errors++; $display("FAIL stall_pc got %h exp 8", bus.if_pc); end
            if (bus.if_instr !== mem[2]) begin errors++; $display("FAIL stall_instr got %h exp %h", bus.if_instr, mem[2]); end
            if (bus.imem_addr !== 32'd12) begin errors++; $display("FAIL stall_addr got %h exp c", bus.imem_addr); end
            if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", bus.if_valid); end
        end
        bus.id_ready = 1'b1;
        tick();
        checks += 2;
        if (bus.if_pc !== 32'd12) begin errors++; $display("FAIL release_pc got %h exp c", bus.if_pc); end
        if (bus.if_instr !== mem[3]) begin errors++; $display("FAIL release_instr got %h exp %h", bus.if_instr, mem[3]); end
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd4;
        tick();
        checks += 2;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b exp 0", bus.if_valid); end
        if (bus.imem_addr !== 32'd4) begin errors++; $display("FAIL redir_addr got %h exp 4", bus.imem_addr); end
        bus.redirect_valid = 1'b0;
        tick();
        checks += 3;
        if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got %b exp 1", bus.if_valid); end
        if (bus.if_pc !== 32'd4) begin errors++; $display("FAIL redir_pc got %h exp 4", bus.if_pc); end
        if (bus.if_instr !== mem[1]) begin errors++; $display("FAIL redir_instr got %h exp %h", bus.if_instr, mem[1]); end
    endtask

    task automatic test_zero_word();
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks += 1;
            if (bus.if_pc !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc%0d got %h exp %h", i, bus.if_pc, 4 * i); end
        end
        tick();
        if (ZH) begin
            checks += 3;
            if (bus.halted !== 1'b1) begin errors++; $display("FAIL zh_halted got %b exp 1", bus.halted); end
            if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL zh_valid got %b exp 0", bus.if_valid); end
            if (bus.imem_addr !== 32'd20) begin errors++; $display("FAIL zh_addr got %h exp 14", bus.imem_addr); end
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = 32'h0;
            tick();
            bus.redirect_valid = 1'b0;
            checks += 2;
            if (bus.halted !== 1'b0) begin errors++; $display("FAIL zh_resume_halted got %b exp 0", bus.halted); end
            if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL zh_resume_bubble got %b exp 0", bus.if_valid); end
            tick();
            checks += 2;
            if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL zh_resume_pc got %h exp 0", bus.if_pc); end
            if (bus.if_instr !== mem[0]) begin errors++; $display("FAIL zh_resume_instr got %h exp %h", bus.if_instr, mem[0]); end
        end else begin
            checks += 3;
            if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %b exp 1", bus.if_valid); end
            if (bus.if_pc !== 32'd20) begin errors++; $display("FAIL zw_pc got %h exp 14", bus.if_pc); end
            if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL zw_instr got %h exp 0", bus.if_instr); end
            tick();
            checks += 3;
            if (bus.fault !== 1'b1) begin errors++; $display("FAIL end_fault got %b exp 1", bus.fault); end
            if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL end_valid got %b exp 0", bus.if_valid); end
            if (bus.imem_addr !== 32'd24) begin errors++; $display("FAIL end_addr got %h exp 18", bus.imem_addr); end
        end
    endtask

    task automatic check_fault_at(input logic [31:0] target, input string nm);
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = target;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 2;
        if (bus.fault !== 1'b0) begin errors++; $display("FAIL %s_early_fault got %b exp 0", nm, bus.fault); end
        if (bus.imem_addr !== target) begin errors++; $display("FAIL %s_redir_addr got %h exp %h", nm, bus.imem_addr, target); end
        tick();
        checks += 3;
        if (bus.fault !== 1'b1) begin errors++; $display("FAIL %s_fault got %b exp 1", nm, bus.fault); end
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %b exp 0", nm, bus.if_valid); end
        if (bus.imem_addr !== target) begin errors++; $display("FAIL %s_addr got %h exp %h", nm, bus.imem_addr, target); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        bus.redirect_valid = 1'b0;
        checks += 3;
        if (bus.fault !== 1'b1) begin errors++; $display("FAIL %s_sticky got %b exp 1", nm, bus.fault); end
        if (bus.imem_addr !== target) begin errors++; $display("FAIL %s_ignore_addr got %h exp %h", nm, bus.imem_addr, target); end
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL %s_ignore_valid got %b exp 0", nm, bus.if_valid); end
    endtask

    task automatic test_out_of_range();
        check_fault_at(32'd24, "range");
        check_fault_at(32'hFFFF_FFFC, "wrap");
    endtask

    task automatic test_misaligned();
        check_fault_at(32'h0000_0006, "misalign");
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.id_ready = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", bus.if_valid); end
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr got %h exp 0", bus.imem_addr); end
        if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL async_pc got %h exp 0", bus.if_pc); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] targets [10];
        logic        rdy, rv;
        logic [31:0] rpc;
        targets = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20,
                    32'd24, 32'd6, 32'd2, 32'hFFFF_FFFC};
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
                continue;
            end
            rdy = $urandom_range(0, 3) != 0;
            rv  = $urandom_range(0, 9) == 0;
            rpc = targets[$urandom_range(0, 9)];
            bus.id_ready = rdy;
            bus.redirect_valid = rv;
            bus.redirect_pc = rpc;
            model_step(rdy, rv, rpc);
            tick();
            checks += 4;
            if (bus.if_valid !== m_v) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, bus.if_valid, m_v); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, bus.imem_addr, m_pc); end
            if (bus.halted !== (m_mode == 1)) begin errors++; $display("FAIL rnd_halted c%0d got %b exp %b", c, bus.halted, m_mode == 1); end
            if (bus.fault !== (m_mode == 2)) begin errors++; $display("FAIL rnd_fault c%0d got %b exp %b", c, bus.fault, m_mode == 2); end
            if (m_v) begin
                checks += 2;
                if (bus.if_pc !== m_ipc) begin errors++; $display("FAIL rnd_pc c%0d got %h exp %h", c, bus.if_pc, m_ipc); end
                if (bus.if_instr !== m_instr) begin errors++; $display("FAIL rnd_instr c%0d got %h exp %h", c, bus.if_instr, m_instr); end
            end
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 5; i++) mem[i] = $urandom | 32'h1;
        mem[5] = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_zero_word();
        test_out_of_range();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
